pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined control unit for the WISC CPU core, the parametrised successor to the single-cycle opcode decoder. Decodes the ID-stage opcode into a control bundle and carries it through registered ID/EX, EX/MEM and MEM/WB stages. Detects RAW hazards and generates stalls, squashes younger instructions on a taken branch, and flags illegal opcodes. Sits between the IF/ID pipeline register and the datapath stage registers.

## Interface
- REG_W, 4: register-address width
- FLUSH_DEPTH, 1: cycles `flush` is held after a taken branch (1..3)
- CNT_W, 16: width of the saturating stall counter
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  4  ID-stage opcode
- id_valid  in  1  ID holds a valid instruction
- id_rs, id_rt, id_rd  in  REG_W each  ID source/destination register addresses
- branch_taken  in  1  EX-stage branch resolved taken (one-cycle pulse)
- stall  out  1  hold PC and IF/ID (combinational)
- flush  out  1  squash IF/ID (registered, counter-driven)
- ex_alu_src, ex_reg_dst, ex_branch  out  1 each  EX-stage controls
- mem_read, mem_write  out  1 each  MEM-stage controls
- wb_reg_write, wb_mem_to_reg  out  1 each  WB-stage controls
- wb_rd  out  REG_W  WB destination register
- illegal  out  1  sticky illegal-opcode flag
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Decode (only when id_valid=1; otherwise the bundle is all-zero):
  - 0000–0011, 0111, 1110: reg_dst, reg_write
  - 0100–0110: alu_src, reg_write
  - 1000: alu_src, mem_read, reg_write, mem_to_reg
  - 1001: alu_src, mem_write
  - 1010, 1011: reg_dst, alu_src, reg_write
  - 1100, 1101: branch
  - 1111: all-zero bundle; sets `illegal`, which stays set until rst.
- Source use:
  - uses_rt for 0000–0011, 0111, 1001.
  - uses_rs for all valid opcodes except 1100, 1110, 1111.
- Register 0 never creates a hazard.
- Each stage register carries its control bits plus its rd; rd is taken from the stage's own destination register.
- Hazard: compare each used ID source against the rd of every older stage whose reg_write=1, according to the rules under Configuration.
- Stall:
  - `stall`=1 loads a bubble (all-zero bundle) into ID/EX.
  - EX/MEM and MEM/WB continue to advance.
- Flush:
  - branch_taken loads the flush counter with FLUSH_DEPTH.
  - `flush`=1 while the counter is non-zero; the counter decrements each cycle.
  - While `flush`=1, ID/EX loads a bubble.
- Simultaneous branch_taken and hazard: flush wins and `stall` is forced to 0.
- branch_taken while the counter is non-zero reloads the counter to FLUSH_DEPTH.
- stall_cnt increments on each cycle with `stall`=1 and saturates at all-ones.

## Timing
- Reset: every output and stage register is 0, the flush counter is 0, `illegal`=0 and stall_cnt=0. All take effect immediately on rst assertion.
- Decode to ex_* outputs: 1 cycle. To mem_*: 2 cycles. To wb_*: 3 cycles.
- `stall` is combinational from the ID inputs and the stage registers, and is valid in the same cycle.
- `flush` rises in the cycle after branch_taken and stays high for exactly FLUSH_DEPTH cycles.
- rst mid-stall or mid-flush: the pipeline empties, and the ID instruction is re-evaluated on the first edge after release.

## Configuration
- FORWARD_EN defined:
  - The datapath forwards EX/MEM and MEM/WB results.
  - A hazard is raised only on load-use: ID source == ex rd with ex mem_read=1.
  - Such a hazard stalls for exactly 1 cycle.
- FORWARD_EN undefined:
  - A hazard is raised on any match against EX, MEM or WB stages with reg_write=1.
  - `stall` holds until no match remains, up to 3 cycles.

## Test plan
- Reset, then opcode 1000 with id_valid=1 → ex_alu_src=1 next cycle; mem_read=1 after 2 cycles; wb_reg_write=1 and wb_mem_to_reg=1 after 3 cycles.
- LW rd=3, then ADD rs=3 → with FORWARD_EN: stall=1 for 1 cycle and stall_cnt=1. Without FORWARD_EN: stall=1 for 3 cycles and stall_cnt=3.
- ADD rd=0, then SUB rs=0 → stall stays 0.
- branch_taken pulse with FLUSH_DEPTH=2 → flush=1 for 2 cycles; ex_* are all-zero during the flush window.
- branch_taken coincident with a load-use hazard → stall=0 and flush=1 next cycle.
- opcode 1111 → illegal=1 and remains 1 after 10 further valid ops; a rst pulse clears it and all outputs to 0 asynchronously.

Source files
------------

// File: rtl/pipe_ctrl_unit_if.sv
// Bus interface for pipe_ctrl_unit: ID-stage inputs, hazard/flush controls
// and the per-stage control outputs. The DUT connects through the slave
// modport; the driving environment uses the master modport.
interface pipe_ctrl_unit_if #(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
);
    // ID-stage inputs
    logic [3:0]       opcode;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             branch_taken;

    // Pipeline control outputs
    logic             stall;
    logic             flush;
    logic             ex_alu_src;
    logic             ex_reg_dst;
    logic             ex_branch;
    logic             mem_read;
    logic             mem_write;
    logic             wb_reg_write;
    logic             wb_mem_to_reg;
    logic [REG_W-1:0] wb_rd;
    logic             illegal;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output opcode, id_valid, id_rs, id_rt, id_rd, branch_taken,
        input  stall, flush, ex_alu_src, ex_reg_dst, ex_branch,
        input  mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_rd,
        input  illegal, stall_cnt
    );

    modport slave (
        input  opcode, id_valid, id_rs, id_rt, id_rd, branch_taken,
        output stall, flush, ex_alu_src, ex_reg_dst, ex_branch,
        output mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_rd,
        output illegal, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the WISC core: decodes the ID-stage opcode,
// carries the control bundle through ID/EX, EX/MEM and MEM/WB, raises RAW
// stalls, squashes on taken branches and flags illegal opcodes.
// Optional feature macro: FORWARD_EN (load-use-only hazard detection when the
// datapath forwards EX/MEM and MEM/WB results).
module pipe_ctrl_unit #(
    parameter int unsigned REG_W       = 4,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned CNT_W       = 16
) (
    input logic             clk,
    input logic             rst,
    pipe_ctrl_unit_if.slave bus
);

    typedef struct packed {
        logic             alu_src;
        logic             reg_dst;
        logic             branch;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] rd;
    } ctrl_t;

    localparam logic [1:0] FlushLoad = 2'(FLUSH_DEPTH);

    ctrl_t            dec;
    logic             uses_rs;
    logic             uses_rt;
    logic             id_illegal;

    ctrl_t            id_ex_q, id_ex_d;
    ctrl_t            ex_mem_q;
    ctrl_t            mem_wb_q;

    logic [1:0]       flush_cnt_q, flush_cnt_d;
    logic             flush_int;
    logic             hazard;
    logic             stall_int;
    logic             illegal_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // True when an in-use, non-zero source matches a writing stage's rd.
    function automatic logic src_hit(input logic [REG_W-1:0] src, input logic used,
                                     input ctrl_t st);
        return used && (src != '0) && st.reg_write && (src == st.rd);
    endfunction

    // Opcode decode into the control bundle and source-use flags.
    always_comb begin
        dec        = '0;
        uses_rs    = 1'b0;
        uses_rt    = 1'b0;
        id_illegal = 1'b0;
        if (bus.id_valid) begin
            case (bus.opcode)
                4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1110: begin
                    dec.reg_dst   = 1'b1;
                    dec.reg_write = 1'b1;
                end
                4'b0100, 4'b0101, 4'b0110: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                end
                4'b1000: begin
                    dec.alu_src    = 1'b1;
                    dec.mem_read   = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = 1'b1;
                end
                4'b1001: begin
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                end
                4'b1010, 4'b1011: begin
                    dec.reg_dst   = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                end
                4'b1100, 4'b1101: begin
                    dec.branch = 1'b1;
                end
                default: begin
                    id_illegal = 1'b1;
                end
            endcase

            // Keep the bundle all-zero for non-writing instructions.
            if (dec.reg_write) begin
                dec.rd = bus.id_rd;
            end

            case (bus.opcode)
                4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1001: uses_rt = 1'b1;
                default:                                              uses_rt = 1'b0;
            endcase

            case (bus.opcode)
                4'b1100, 4'b1110, 4'b1111: uses_rs = 1'b0;
                default:                   uses_rs = 1'b1;
            endcase
        end
    end

    // RAW hazard detection against the older stages.
    always_comb begin
        hazard = 1'b0;
`ifdef FORWARD_EN
        // Only a load in EX cannot be forwarded in time.
        if (id_ex_q.mem_read) begin
            hazard = src_hit(bus.id_rs, uses_rs, id_ex_q) ||
                     src_hit(bus.id_rt, uses_rt, id_ex_q);
        end
`else
        hazard = src_hit(bus.id_rs, uses_rs, id_ex_q)  ||
                 src_hit(bus.id_rt, uses_rt, id_ex_q)  ||
                 src_hit(bus.id_rs, uses_rs, ex_mem_q) ||
                 src_hit(bus.id_rt, uses_rt, ex_mem_q) ||
                 src_hit(bus.id_rs, uses_rs, mem_wb_q) ||
                 src_hit(bus.id_rt, uses_rt, mem_wb_q);
`endif
    end

    // Stall gating: a taken branch or active flush overrides a hazard, since
    // the instruction in ID is being squashed anyway.
    always_comb begin
        flush_int = (flush_cnt_q != 2'd0);
        stall_int = hazard && !bus.branch_taken && !flush_int;
    end

    // Flush counter next state: reload on taken branch, else count down.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (bus.branch_taken) begin
            flush_cnt_d = FlushLoad;
        end else if (flush_cnt_q != 2'd0) begin
            flush_cnt_d = flush_cnt_q - 2'd1;
        end
    end

    // ID/EX next state: bubble on stall or flush.
    always_comb begin
        id_ex_d = dec;
        if (stall_int || flush_int) begin
            id_ex_d = '0;
        end
    end

    // Stage registers; EX/MEM and MEM/WB always advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= id_ex_q;
            mem_wb_q <= ex_mem_q;
        end
    end

    // Flush counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= 2'd0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Sticky illegal-opcode flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (id_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_int && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Drive the bus outputs from the stage registers.
    always_comb begin
        bus.stall         = stall_int;
        bus.flush         = flush_int;
        bus.ex_alu_src    = id_ex_q.alu_src;
        bus.ex_reg_dst    = id_ex_q.reg_dst;
        bus.ex_branch     = id_ex_q.branch;
        bus.mem_read      = ex_mem_q.mem_read;
        bus.mem_write     = ex_mem_q.mem_write;
        bus.wb_reg_write  = mem_wb_q.reg_write;
        bus.wb_mem_to_reg = mem_wb_q.mem_to_reg;
        bus.wb_rd         = mem_wb_q.rd;
        bus.illegal       = illegal_q;
        bus.stall_cnt     = stall_cnt_q;
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (FLUSH_DEPTH=2, CNT_W=2 so
// stall_cnt saturation is reachable). Honours FORWARD_EN if defined.
module tb_pipe_ctrl_unit;

    localparam int unsigned RW = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned FD = 2;

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpLw  = 4'b1000;
    localparam logic [3:0] OpIll = 4'b1111;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

`ifdef FORWARD_EN
    localparam logic [3:0] ExpStall = 4'b0001;
    localparam int         ExpCnt1  = 1;
    localparam int         ExpCnt2  = 2;
`else
    localparam logic [3:0] ExpStall = 4'b0111;
    localparam int         ExpCnt1  = 3;
    localparam int         ExpCnt2  = 3;
`endif

    pipe_ctrl_unit_if #(.REG_W(RW), .CNT_W(CW)) bus ();

    pipe_ctrl_unit #(
        .REG_W      (RW),
        .FLUSH_DEPTH(FD),
        .CNT_W      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [3:0] op, input logic v, input logic [3:0] rs,
                          input logic [3:0] rt, input logic [3:0] rd);
        bus.opcode   = op;
        bus.id_valid = v;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.id_rd    = rd;
    endtask

    function automatic logic [2:0] ex_bits();
        return {bus.ex_alu_src, bus.ex_reg_dst, bus.ex_branch};
    endfunction

    // LW r3 followed by ADD rs=r3; checks stall pattern, bubble and count.
    task automatic load_use(input string tag, input int exp_cnt);
        logic [3:0] exp_stall;
        exp_stall = ExpStall;
        set_id(OpLw, 1'b1, 4'd1, 4'd3, 4'd3);
        #1 chk({tag, "_lw_stall"}, 32'(bus.stall), 32'd0);
        tick();
        set_id(OpAdd, 1'b1, 4'd3, 4'd2, 4'd4);
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("%s_stall%0d", tag, i), 32'(bus.stall), 32'(exp_stall[i]));
            if (i == 1) begin
                chk({tag, "_bubble"}, 32'(ex_bits()), 32'd0);
            end
            tick();
        end
        set_id(OpAdd, 1'b0, 4'd0, 4'd0, 4'd0);
        chk({tag, "_ex_add"}, 32'(ex_bits()), 32'b010);
        chk({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_cnt));
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst              = 1'b1;
        bus.branch_taken = 1'b0;
        set_id(4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        #2;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_ex", 32'(ex_bits()), 32'd0);
        chk("rst_mem", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        chk("rst_wb", 32'({bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_rd}), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // LW propagation through EX, MEM, WB
        set_id(OpLw, 1'b1, 4'd1, 4'd3, 4'd3);
        #1 chk("lw_no_stall", 32'(bus.stall), 32'd0);
        tick();
        set_id(OpLw, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("lw_ex", 32'(ex_bits()), 32'b100);
        tick();
        chk("lw_mem", 32'({bus.mem_read, bus.mem_write}), 32'b10);
        tick();
        chk("lw_wb", 32'({bus.wb_reg_write, bus.wb_mem_to_reg}), 32'b11);
        chk("lw_wb_rd", 32'(bus.wb_rd), 32'd3);
        tick();
        chk("drain_wb", 32'({bus.wb_reg_write, bus.wb_mem_to_reg}), 32'b00);

        // Load-use hazard, then again to hit stall_cnt saturation
        load_use("lu1", ExpCnt1);
        load_use("lu2", ExpCnt2);

        // Register 0 never hazards
        set_id(OpAdd, 1'b1, 4'd1, 4'd2, 4'd0);
        tick();
        set_id(OpSub, 1'b1, 4'd0, 4'd0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("r0_stall%0d", i), 32'(bus.stall), 32'd0);
            tick();
        end
        set_id(OpSub, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("r0_stall_cnt", 32'(bus.stall_cnt), 32'(ExpCnt2));
        tick();
        tick();
        tick();

        // Branch flush window (FLUSH_DEPTH=2)
        bus.branch_taken = 1'b1;
        #1 chk("br_flush_pre", 32'(bus.flush), 32'd0);
        tick();
        bus.branch_taken = 1'b0;
        set_id(OpAdd, 1'b1, 4'd1, 4'd2, 4'd5);
        #1 chk("br_flush0", 32'(bus.flush), 32'd1);
        chk("br_ex0", 32'(ex_bits()), 32'd0);
        tick();
        chk("br_flush1", 32'(bus.flush), 32'd1);
        chk("br_ex1", 32'(ex_bits()), 32'd0);
        tick();
        chk("br_flush2", 32'(bus.flush), 32'd0);
        chk("br_ex2", 32'(ex_bits()), 32'd0);
        tick();
        chk("br_ex_add", 32'(ex_bits()), 32'b010);
        set_id(OpAdd, 1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        tick();

        // Branch coincident with load-use hazard
        set_id(OpLw, 1'b1, 4'd1, 4'd3, 4'd3);
        tick();
        set_id(OpAdd, 1'b1, 4'd3, 4'd2, 4'd4);
        bus.branch_taken = 1'b1;
        #1 chk("co_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.branch_taken = 1'b0;
        set_id(OpAdd, 1'b0, 4'd0, 4'd0, 4'd0);
        chk("co_flush", 32'(bus.flush), 32'd1);
        chk("co_stall_cnt", 32'(bus.stall_cnt), 32'(ExpCnt2));
        for (int i = 0; i < 4; i++) tick();

        // Illegal opcode is sticky
        set_id(OpIll, 1'b1, 4'd1, 4'd2, 4'd3);
        tick();
        chk("ill_set", 32'(bus.illegal), 32'd1);
        chk("ill_ex", 32'(ex_bits()), 32'd0);
        for (int i = 0; i < 10; i++) begin
            set_id(4'(i % 4), 1'b1, 4'd0, 4'd0, 4'(i + 1));
            tick();
        end
        chk("ill_sticky", 32'(bus.illegal), 32'd1);

        // Asynchronous reset mid-stall clears everything
        set_id(OpLw, 1'b1, 4'd1, 4'd3, 4'd3);
        tick();
        set_id(OpAdd, 1'b1, 4'd3, 4'd2, 4'd4);
        #1 chk("ar_pre_stall", 32'(bus.stall), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_illegal", 32'(bus.illegal), 32'd0);
        chk("ar_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("ar_ex", 32'(ex_bits()), 32'd0);
        chk("ar_mem", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        chk("ar_wb", 32'({bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_rd}), 32'd0);
        chk("ar_flush", 32'(bus.flush), 32'd0);
        chk("ar_stall", 32'(bus.stall), 32'd0);
        #1 rst = 1'b0;
        tick();
        chk("ar_reeval_ex", 32'(ex_bits()), 32'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
